// File: rtl/divide_unit.sv
// Sequential restoring divider: one shift and one trial-subtract per two clocks, results held until Run drops.
// Optional two's-complement mode is enabled by defining DIVIDE_UNIT_SIGNED_EN.
module divide_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_TRIAL = 3'd2,
    S_FIX   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_R;
  logic [WIDTH-1:0] r_Q;
  logic [WIDTH-1:0] r_D;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;
  logic [WIDTH:0]   w_diff;
  logic             w_last;

`ifdef DIVIDE_UNIT_SIGNED_EN
  logic r_sd;
  logic r_sv;

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`endif

  assign w_diff = {1'b0, r_R} - {1'b0, r_D};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Run) w_next = (Din == '0) ? S_HOLD : S_SHIFT;
      S_SHIFT: w_next = S_TRIAL;
`ifdef DIVIDE_UNIT_SIGNED_EN
      S_TRIAL: w_next = w_last ? S_FIX : S_SHIFT;
      S_FIX:   w_next = S_HOLD;
`else
      S_TRIAL: w_next = w_last ? S_HOLD : S_SHIFT;
`endif
      S_HOLD:  if (!Run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Done = (r_state == S_HOLD);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_R   <= '0;
      r_Q   <= '0;
      r_D   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
`ifdef DIVIDE_UNIT_SIGNED_EN
      r_sd  <= 1'b0;
      r_sv  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_cnt <= '0;
            r_dbz <= (Din == '0);
            if (Din == '0) begin
              // Divide by zero: quotient saturates, remainder keeps the dividend
              r_D <= Din;
              r_Q <= '1;
              r_R <= r_Q;
            end else begin
`ifdef DIVIDE_UNIT_SIGNED_EN
              r_D  <= f_mag(Din);
              r_Q  <= f_mag(r_Q);
              r_sd <= r_Q[WIDTH-1];
              r_sv <= Din[WIDTH-1];
`else
              r_D  <= Din;
`endif
            end
          end else if (ClearA_LoadB) begin
            r_Q   <= Din;
            r_R   <= '0;
            r_dbz <= 1'b0;
          end
        end
        S_SHIFT: {r_R, r_Q} <= {r_R[WIDTH-2:0], r_Q, 1'b0};
        S_TRIAL: begin
          // Restore is implicit: a negative trial difference is simply not written back
          if (!w_diff[WIDTH]) begin
            r_R    <= w_diff[WIDTH-1:0];
            r_Q[0] <= 1'b1;
          end
          if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
`ifdef DIVIDE_UNIT_SIGNED_EN
        S_FIX: begin
          if (r_sd ^ r_sv) r_Q <= -r_Q;
          if (r_sd)        r_R <= -r_R;
        end
`endif
        default: ;
      endcase
    end
  end

  assign Aval      = r_R;
  assign Bval      = r_Q;
  assign DivByZero = r_dbz;

endmodule

// File: tb/tb_divide_unit.sv
// Directed and randomized bench for divide_unit with an arithmetic reference model.
module tb_divide_unit;

  localparam int W = 8;
`ifdef DIVIDE_UNIT_SIGNED_EN
  localparam int LAT = 2 * W + 1;
`else
  localparam int LAT = 2 * W;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Run = 1'b0;
  logic         ClearA_LoadB = 1'b0;
  logic [W-1:0] Din = '0;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         Done;
  logic         DivByZero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_R = '0;
  logic [W-1:0] m_Q = '0;
  logic         m_dbz = 1'b0;

  divide_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Din(Din), .Aval(Aval), .Bval(Bval), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: dividend = Q*D + R, with the documented divide-by-zero result
  task automatic model(input logic [W-1:0] r0, input logic [W-1:0] q0, input logic [W-1:0] d,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
    ez = (d == '0);
    if (ez) begin
      eq = '1;
      er = q0;
    end else begin
`ifdef DIVIDE_UNIT_SIGNED_EN
      int a, b, qi, ri;
      a  = int'($signed(q0));
      b  = int'($signed(d));
      qi = a / b;
      ri = a % b;
      eq = qi[W-1:0];
      er = ri[W-1:0];
`else
      int unsigned num;
      num = {16'd0, r0, q0};
      eq  = W'(num / int'(d));
      er  = W'(num % int'(d));
`endif
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    Run = 1'b0;
    ClearA_LoadB = 1'b1;
    Din = v;
    tick();
    ClearA_LoadB = 1'b0;
    m_Q = v; m_R = '0; m_dbz = 1'b0;
    check("load_Bval", Bval, m_Q);
    check("load_Aval", Aval, m_R);
    check("load_dbz", DivByZero, m_dbz);
  endtask

  task automatic divide(input string tag, input logic [W-1:0] dvs);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(m_R, m_Q, dvs, eq, er, ez);
    lat = ez ? 0 : LAT;
    Run = 1'b1;
    Din = dvs;
    tick();
    Din = W'($urandom);
    if (lat > 0) begin
      repeat (lat - 1) tick();
      check({tag, "_done_early"}, Done, 1'b0);
      tick();
    end
    check({tag, "_done"}, Done, 1'b1);
    check({tag, "_Bval"}, Bval, eq);
    check({tag, "_Aval"}, Aval, er);
    check({tag, "_dbz"}, DivByZero, ez);
    // Run still high plus a load request: results must stay frozen
    ClearA_LoadB = 1'b1;
    Din = W'($urandom);
    tick();
    ClearA_LoadB = 1'b0;
    check({tag, "_hold_done"}, Done, 1'b1);
    check({tag, "_hold_Bval"}, Bval, eq);
    check({tag, "_hold_Aval"}, Aval, er);
    Run = 1'b0;
    tick();
    check({tag, "_idle_done"}, Done, 1'b0);
    check({tag, "_idle_Bval"}, Bval, eq);
    m_Q = eq; m_R = er; m_dbz = ez;
  endtask

  initial begin
    logic [W-1:0] dvd, dvs;

    #3;
    check("rst_Aval", Aval, 0);
    check("rst_Bval", Bval, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    Reset_n = 1'b1;
    tick();

    load(8'd100); divide("basic", 8'd7);
    load(8'd255); divide("max", 8'd1);
    load(8'd3);   divide("small", 8'd200);

    load(8'd5);   divide("dbz", 8'd0);
    load(8'd9);
    check("dbz_cleared", DivByZero, 0);

    // Run and ClearA_LoadB together: Run wins, the load is ignored
    load(8'd50);
    ClearA_LoadB = 1'b1;
    divide("both", 8'd6);

    // Re-run straight from the previous quotient
    load(8'd100); divide("first", 8'd5);
    divide("rerun", 8'd3);

    // Asynchronous reset during the fourth trial step
    load(8'd100);
    Run = 1'b1; Din = 8'd7;
    tick();
    repeat (7) tick();
    #2 Reset_n = 1'b0;
    Run = 1'b0;
    #1;
    check("midrst_Aval", Aval, 0);
    check("midrst_Bval", Bval, 0);
    check("midrst_done", Done, 0);
    #2 Reset_n = 1'b1;
    tick();
    check("midrst_idle_done", Done, 0);
    load(8'd100); divide("after_rst", 8'd7);

`ifdef DIVIDE_UNIT_SIGNED_EN
    load(8'hF9); divide("s_neg_pos", 8'd2);
    check("s_m7_2_Q", Bval, 8'hFD);
    check("s_m7_2_R", Aval, 8'hFF);
    load(8'd7);  divide("s_pos_neg", 8'hFE);
    check("s_7_m2_Q", Bval, 8'hFD);
    check("s_7_m2_R", Aval, 8'h01);
    load(8'h80); divide("s_wrap", 8'hFF);
    check("s_wrap_Q", Bval, 8'h80);
    check("s_wrap_R", Aval, 8'h00);
`else
    check("basic_const_Q", 32'(100 / 7), 32'd14);
`endif

    for (int i = 0; i < 24; i++) begin
      dvd = W'($urandom);
      dvs = (i % 8 == 7) ? 8'd0 : W'($urandom_range(1, 255));
      load(dvd);
      divide("rand", dvs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divide_unit.md
# divide_unit

Sequential restoring divider with an integrated controller and datapath. It is the division counterpart of the lab's shift-add multiplier and uses the same user-facing convention:
- Switch bus `Din` supplies the operands.
- `ClearA_LoadB` loads the dividend.
- `Run` starts the operation.
- The results sit on the `Aval`/`Bval` register outputs for the hex displays.

One iteration of shift and trial-subtract runs per two clocks, and the unit then holds its results until `Run` is released.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width.
- `Clk` input 1: system clock; all state updates on the rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Run` input 1: level start request. Already synchronized and debounced upstream.
- `ClearA_LoadB` input 1: level load request. Already synchronized and debounced upstream.
- `Din` input WIDTH: operand switches.
- `Aval` output WIDTH: remainder register R.
- `Bval` output WIDTH: dividend/quotient register Q.
- `Done` output 1: high while in HOLD.
- `DivByZero` output 1: sticky error flag for the last operation.

## Operation
Registers:
- R (WIDTH bits): remainder.
- Q (WIDTH bits): dividend, becoming the quotient.
- D (WIDTH bits): divisor.
- Iteration counter: 0..WIDTH-1.

States: IDLE, SHIFT, TRIAL, FIX (present only with the signed feature), HOLD.

IDLE:
- **Run=1:**
  - D <= Din.
  - DivByZero <= (Din==0).
  - Counter <= 0.
  - If Din==0: Q <= all ones, R <= the original dividend, go to HOLD.
  - Otherwise go to SHIFT.
- **Run=0 and ClearA_LoadB=1:** Q <= Din, R <= 0, DivByZero <= 0. Stay in IDLE.
- **Both high:** Run has priority; ClearA_LoadB is ignored that cycle.

SHIFT:
- {R,Q} <= {R,Q} << 1, with Q[0] <= 0.
- Go to TRIAL.

TRIAL:
- Compute diff = {1'b0,R} - {1'b0,D} at WIDTH+1 bits.
- If diff[WIDTH]==0: R <= diff[WIDTH-1:0] and Q[0] <= 1.
- Otherwise R and Q are unchanged (restore by not writing).
- If counter==WIDTH-1, go to HOLD (to FIX when signed). Otherwise counter++ and go to SHIFT.

HOLD:
- Done=1. Registers are frozen.
- ClearA_LoadB is ignored.
- Run=0 returns to IDLE with results retained. Run held high stays in HOLD.

Arithmetic:
- The result satisfies dividend = Q*D + R with R < D.
- No overflow is possible for unsigned operands.

Reset and boundary conditions:
- Reset_n low at any time, including mid-operation, forces IDLE immediately. The current operation is lost.
- Reset values: Aval=0, Bval=0, Done=0, DivByZero=0, counter=0.
- Din changes during SHIFT/TRIAL are ignored, because D is captured only on the IDLE->SHIFT edge.

## Timing
- Let k be the edge at which IDLE samples Run=1.
- Unsigned: state is SHIFT after k and HOLD after edge k+2·WIDTH. With WIDTH=8, Done rises after edge k+16.
- Signed: one extra cycle for FIX, so Done rises after edge k+2·WIDTH+1.
- Divide by zero: Done rises after edge k.
- Minimum spacing between operations: Run must be low for at least one cycle, passing through IDLE.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `DIVIDE_UNIT_SIGNED_EN`.
- **Defined:** operands are two's complement.
  - On the IDLE->SHIFT edge, Q and D are replaced by their magnitudes. The signs of the dividend (sd) and divisor (sv) are latched.
  - FIX state: Q <= -Q if sd^sv, R <= -R if sd, then go to HOLD.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - -128/-1 gives Q=0x80, R=0 (natural wrap, no flag).
  - Divide by zero behaves as in unsigned mode.
- **Undefined:** FIX is absent; operands are unsigned; latency is 2·WIDTH.

## Test plan
- **Basic divide:** load 100 via ClearA_LoadB, Din=7, pulse Run -> 16 cycles later Done=1, Bval=0x0E, Aval=0x02, DivByZero=0.
- **Max dividend:** load 255, divisor 1 -> Bval=0xFF, Aval=0x00. Then load 3, divisor 200 -> Bval=0x00, Aval=0x03.
- **Divide by zero:** load 5, Din=0, Run -> Done after 1 cycle, Bval=0xFF, Aval=0x05, DivByZero=1. Next ClearA_LoadB in IDLE clears DivByZero.
- **Run held and ClearA_LoadB in HOLD:** hold Run high through HOLD and pulse ClearA_LoadB -> results unchanged, no restart. Drop Run -> IDLE. Raise Run again -> new operation with Q = previous quotient.
- **Reset mid-operation:** assert Reset_n low at TRIAL of iteration 4 -> outputs 0 asynchronously, state IDLE. Release -> new 100/7 completes correctly.
- **Signed (macro defined):** -7/2 -> Bval=0xFD, Aval=0xFF at edge k+17. Also 7/-2 -> 0xFD/0x01, and -128/-1 -> 0x80/0x00.
